aes_key_sched_ctrl: RTL and testbench

Sequencer that sits directly upstream of the single-round key expansion stage: accepts a 128-bit AES cipher key over a valid/ready handshake, drives the expansion stage once per round with the previous round key and the matching rcon, and captures each returned round key. All 11 round keys (rk0..rk10) are held in a local store with a registered read port for the cipher datapath.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_rk_store.sv | 40 ++++
 rtl/aes_key_sched_ctrl.sv | 130 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, rcon helper and sequencer state type for the AES key schedule.
package aes_pkg;

   localparam int unsigned KEY_W     = 128;
   localparam int unsigned NR        = 10;
   localparam int unsigned IDX_W     = 4;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      GAP    = 2'd2,
      DONE   = 2'd3
   } ks_state_e;

   // GF(2^8) multiply-by-x with the AES reduction polynomial
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: (NR+1) x KEY_W, one write port, registered read.
// Ports:
//   clk_i, rst_i        clock, synchronous active-low clear of every entry and rdata_o
//   we_i/waddr_i/wdata_i write port
//   raddr_i/rdata_o     registered read; out-of-range index returns 0
module aes_rk_store
   import aes_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [KEY_W-1:0] wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [KEY_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = NR + 1;

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [KEY_W-1:0] rdata_q;

   // Read samples the pre-write contents, so a same-cycle write shows up on the next read
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
         end
         rdata_q <= (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: accepts a cipher key, drives the external
// single-round expansion stage once per round and stores rk0..rk10.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-low reset
//   key_valid_i/key_ready_o/key_i     cipher key handshake
//   xp_req_o/xp_key_o/xp_rcon_o       request to the expansion stage
//   xp_valid_i/xp_key_i               expansion stage result
//   rk_idx_i/rk_o                     registered round-key read port
//   sched_done_o, busy_o              status
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             key_valid_i,
   output logic             key_ready_o,
   input  logic [KEY_W-1:0] key_i,
   output logic             xp_req_o,
   output logic [KEY_W-1:0] xp_key_o,
   output logic [7:0]       xp_rcon_o,
   input  logic             xp_valid_i,
   input  logic [KEY_W-1:0] xp_key_i,
   input  logic [IDX_W-1:0] rk_idx_i,
   output logic [KEY_W-1:0] rk_o,
   output logic             sched_done_o,
   output logic             busy_o
);

   ks_state_e        state_q, state_d;
   logic [IDX_W-1:0] round_q, round_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [KEY_W-1:0] cur_key_q, cur_key_d;
   logic             req_q, req_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             we_c;
   logic [IDX_W-1:0] waddr_c;
   logic [KEY_W-1:0] wdata_c;

   // Next-state, round/rcon update and store write; status outputs follow state_d
   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      rcon_d    = rcon_q;
      cur_key_d = cur_key_q;
      we_c      = 1'b0;
      waddr_c   = round_q;
      wdata_c   = xp_key_i;

      unique case (state_q)
         IDLE, DONE: begin
            if (key_valid_i && ready_q) begin
               we_c      = 1'b1;
               waddr_c   = '0;
               wdata_c   = key_i;
               cur_key_d = key_i;
               round_d   = IDX_W'(1);
               rcon_d    = RCON_INIT;
               state_d   = EXPAND;
            end
         end
         EXPAND: begin
            if (xp_valid_i) begin
               we_c      = 1'b1;
               cur_key_d = xp_key_i;
               if (round_q == IDX_W'(NR)) begin
                  state_d = DONE;
               end else begin
                  round_d = round_q + IDX_W'(1);
                  rcon_d  = xtime(rcon_q);
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            state_d = EXPAND;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_d   = (state_d == EXPAND);
      busy_d  = (state_d == EXPAND) || (state_d == GAP);
      ready_d = (state_d == IDLE) || (state_d == DONE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         round_q   <= '0;
         rcon_q    <= RCON_INIT;
         cur_key_q <= '0;
         req_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         round_q   <= round_d;
         rcon_q    <= rcon_d;
         cur_key_q <= cur_key_d;
         req_q     <= req_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   aes_rk_store u_store (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (we_c),
      .waddr_i (waddr_c),
      .wdata_i (wdata_c),
      .raddr_i (rk_idx_i),
      .rdata_o (rk_o)
   );

   assign key_ready_o  = ready_q;
   assign xp_req_o     = req_q;
   assign xp_key_o     = cur_key_q;
   assign xp_rcon_o    = rcon_q;
   assign sched_done_o = done_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: emulates the expansion stage with a chosen
// latency and checks the store against an AES-128 key expansion model.
module tb_aes_key_sched_ctrl;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         key_valid_i;
   logic         key_ready_o;
   logic [127:0] key_i;
   logic         xp_req_o;
   logic [127:0] xp_key_o;
   logic [7:0]   xp_rcon_o;
   logic         xp_valid_i;
   logic [127:0] xp_key_i;
   logic [3:0]   rk_idx_i;
   logic [127:0] rk_o;
   logic         sched_done_o;
   logic         busy_o;

   int n_checks = 0;
   int n_errors = 0;

   int lat      = 1;
   int rnd      = 0;
   bit stray_en = 1'b0;

   logic [127:0] sched  [11];
   logic [127:0] ref_rk [11];
   logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_key_sched_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .key_i        (key_i),
      .xp_req_o     (xp_req_o),
      .xp_key_o     (xp_key_o),
      .xp_rcon_o    (xp_rcon_o),
      .xp_valid_i   (xp_valid_i),
      .xp_key_i     (xp_key_i),
      .rk_idx_i     (rk_idx_i),
      .rk_o         (rk_o),
      .sched_done_o (sched_done_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // GF(2^8) multiply, shift-and-add
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse (a^254) then affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] w0 = prev[127:96];
      logic [31:0] w1 = prev[95:64];
      logic [31:0] w2 = prev[63:32];
      logic [31:0] w3 = prev[31:0];
      logic [31:0] t, n0, n1, n2, n3;
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   task automatic compute_sched(input logic [127:0] key);
      sched[0] = key;
      for (int i = 1; i <= 10; i++) sched[i] = next_rk(sched[i-1], rcon_tab[i-1]);
   endtask

   // Expansion stage emulator: answers each request after lat cycles; optional stray valids
   initial begin
      int wcnt = 0;
      xp_valid_i = 1'b0;
      xp_key_i   = '0;
      forever begin
         @(negedge clk);
         if (!rst_i) begin
            xp_valid_i = 1'b0;
            wcnt       = 0;
         end else if (xp_req_o) begin
            if (wcnt == lat) begin
               if (rnd < 10) begin
                  check_eq($sformatf("xp_rcon_r%0d", rnd + 1), 128'(xp_rcon_o), 128'(rcon_tab[rnd]));
                  check_eq($sformatf("xp_key_r%0d", rnd + 1), xp_key_o, sched[rnd]);
               end
               rnd++;
               xp_valid_i = 1'b1;
               xp_key_i   = next_rk(xp_key_o, xp_rcon_o);
            end else begin
               xp_valid_i = 1'b0;
               wcnt++;
            end
         end else begin
            wcnt = 0;
            if (stray_en) begin
               xp_valid_i = 1'b1;
               xp_key_i   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               xp_valid_i = 1'b0;
            end
         end
      end
   end

   task automatic start_key(input logic [127:0] key, input int l, input bit hold);
      compute_sched(key);
      lat         = l;
      rnd         = 0;
      key_i       = key;
      key_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (hold) key_i = {$urandom, $urandom, $urandom, $urandom};
      else key_valid_i = 1'b0;
      check_eq("acc_busy",  128'(busy_o),       128'h1);
      check_eq("acc_ready", 128'(key_ready_o),  128'h0);
      check_eq("acc_done",  128'(sched_done_o), 128'h0);
      check_eq("acc_req",   128'(xp_req_o),     128'h1);
      check_eq("acc_rcon",  128'(xp_rcon_o),    128'h01);
   endtask

   // k counts negedges after the accept edge; done seen at k means "T+k+1" in edge terms
   task automatic wait_done(input int l, input int k0);
      int k = k0;
      bit hs_bad = 1'b0;
      while (!sched_done_o && k < 400) begin
         @(negedge clk);
         k++;
         if (busy_o && key_ready_o) hs_bad = 1'b1;
      end
      key_valid_i = 1'b0;
      check_eq($sformatf("done_lat_L%0d", l), 128'(k + 1), 128'(10 * l + 20));
      check_eq("busy_ready_excl", 128'(hs_bad), 128'h0);
      check_eq("done_busy", 128'(busy_o), 128'h0);
      check_eq("done_ready", 128'(key_ready_o), 128'h1);
      for (int i = 0; i <= 10; i++) ref_rk[i] = sched[i];
   endtask

   task automatic read_one(input int i, input logic [127:0] exp, input string tag);
      rk_idx_i = 4'(i);
      @(negedge clk);
      check_eq(tag, rk_o, exp);
   endtask

   task automatic read_all();
      for (int i = 0; i < 16; i++) begin
         if (i <= 10) read_one(i, ref_rk[i], $sformatf("rk%0d", i));
         else read_one(i, 128'h0, $sformatf("rk%0d_oob", i));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 128'(key_ready_o),  128'h1);
      check_eq({tag, "_req"},   128'(xp_req_o),     128'h0);
      check_eq({tag, "_done"},  128'(sched_done_o), 128'h0);
      check_eq({tag, "_busy"},  128'(busy_o),       128'h0);
      check_eq({tag, "_xpkey"}, xp_key_o,           128'h0);
      check_eq({tag, "_rcon"},  128'(xp_rcon_o),    128'h01);
      check_eq({tag, "_rk"},    rk_o,               128'h0);
   endtask

   initial begin
      logic [127:0] k;
      int l;
      int w;

      rst_i       = 1'b0;
      key_valid_i = 1'b0;
      key_i       = '0;
      rk_idx_i    = '0;
      for (int i = 0; i <= 10; i++) ref_rk[i] = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_i = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_rel");

      // Stray valids in IDLE must not touch state or store
      stray_en = 1'b1;
      repeat (4) @(negedge clk);
      stray_en = 1'b0;
      check_eq("idle_stray_busy",  128'(busy_o),      128'h0);
      check_eq("idle_stray_ready", 128'(key_ready_o), 128'h1);
      check_eq("idle_stray_req",   128'(xp_req_o),    128'h0);
      read_all();

      // FIPS-197 key at latencies 1, 0, 3
      start_key(FIPS_KEY, 1, 1'b0);
      wait_done(1, 0);
      read_one(1, FIPS_RK1, "fips_rk1");
      read_one(10, FIPS_RK10, "fips_rk10");
      read_one(0, FIPS_KEY, "fips_rk0");
      read_all();

      start_key(FIPS_KEY, 0, 1'b0);
      wait_done(0, 0);
      read_all();
      read_one(10, FIPS_RK10, "fips_L0_rk10");

      start_key(FIPS_KEY, 3, 1'b0);
      wait_done(3, 0);
      read_all();
      read_one(1, FIPS_RK1, "fips_L3_rk1");

      // key_valid held through a schedule with a changing key_i: no re-accept
      start_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1);
      wait_done(2, 0);
      @(negedge clk);
      check_eq("hold_no_reaccept_busy", 128'(busy_o),       128'h0);
      check_eq("hold_no_reaccept_done", 128'(sched_done_o), 128'h1);
      read_all();

      // New key in DONE: restart, and unwritten entries still hold the old schedule
      start_key({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
      rk_idx_i = 4'd10;
      @(negedge clk);
      check_eq("restart_old_rk10", rk_o, ref_rk[10]);
      wait_done(1, 1);
      read_all();

      // Randomised schedules with stray valids during GAP
      for (int n = 0; n < 4; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         l = int'($urandom_range(0, 3));
         stray_en = 1'b1;
         start_key(k, l, 1'b0);
         wait_done(l, 0);
         stray_en = 1'b0;
         for (int j = 0; j < 4; j++) begin
            w = int'($urandom_range(0, 15));
            if (w <= 10) read_one(w, ref_rk[w], $sformatf("rand_rk%0d", w));
            else read_one(w, 128'h0, $sformatf("rand_rk%0d_oob", w));
         end
      end

      // Reset while round 5 is being requested
      start_key({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
      w = 0;
      while (!(xp_req_o && xp_rcon_o == 8'h10) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("reach_round5", 128'(w < 100), 128'h1);
      rst_i = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_i = 1'b1;
      @(negedge clk);
      check_eq("midrst_rel_ready", 128'(key_ready_o), 128'h1);
      check_eq("midrst_rel_busy",  128'(busy_o),      128'h0);
      for (int i = 0; i <= 10; i++) ref_rk[i] = '0;
      read_all();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
